sccb_config_sequencer: RTL and testbench
========================================

Name: sccb_config_sequencer

Overview:
Parametrised successor to the camera configuration sequencer. It walks an external synchronous configuration ROM of 18-bit opcode entries and drives a byte-level SCCB master through a start/ready handshake. Over the current write-only sequencer it adds:
- configurable device address and ROM depth;
- timed delay entries;
- write-with-readback-verify, with bounded retry;
- error reporting with the failing ROM address.

It sits between the ROM and the SCCB interface inside the camera configuration top.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz; sets the 1 ms delay tick.
ROM_AW, 8, ROM address width; depth is 2^ROM_AW entries.
DEV_ADDR, 8'h42, SCCB 8-bit write address; the read address is DEV_ADDR|1, generated by the master.
MAX_RETRY, 3, number of re-writes allowed after a verify mismatch before failing.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; begins a sequence when sampled high in IDLE, DONE or FAIL
rom_addr  out  ROM_AW  ROM address
rom_data  in  18  ROM entry, valid 1 cycle after rom_addr changes: [17:16] op, [15:8] reg, [7:0] data
sccb_start  out  1  one-cycle transaction request
sccb_rw  out  1  0 = write, 1 = read; valid with sccb_start
sccb_dev_addr  out  8  constant DEV_ADDR
sccb_reg_addr  out  8  register address
sccb_wdata  out  8  write data
sccb_ready  in  1  master idle; rises at transaction end
sccb_rdata  in  8  read byte; valid while sccb_ready=1 after a read
busy  out  1  sequence in progress
done  out  1  sticky; sequence finished (pass or fail)
error  out  1  sticky; verify failed after retries
err_addr  out  ROM_AW  ROM address of the failing entry

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE;
  - rom_addr=0, sccb_start=0, sccb_rw=0, sccb_reg_addr=0, sccb_wdata=0;
  - busy=0, done=0, error=0, err_addr=0, retry count=0, delay counter=0.
  - Reset mid-transaction abandons the transaction immediately; no further sccb_start is issued.
- Opcodes:
  - 00 WRITE.
  - 01 WRITE_VERIFY.
  - 10 DELAY: {reg,data} = milliseconds.
  - 11 END.
- States:
  - IDLE: on start, clear done/error, set rom_addr=0 and busy=1, go to FETCH.
  - FETCH: one wait cycle for the ROM, then latch rom_data. Go to DECODE.
  - DECODE:
    - WRITE / WRITE_VERIFY: go to WR_ISSUE.
    - DELAY: load count, go to DELAY.
    - END: go to DONE.
  - WR_ISSUE: wait for sccb_ready=1, then pulse sccb_start for 1 cycle with sccb_rw=0 and reg/data driven. Go to WR_WAIT.
  - WR_WAIT: ignore sccb_ready in the first cycle after the pulse, then wait for sccb_ready=1.
    - WRITE: go to NEXT.
    - VERIFY: go to RD_ISSUE.
  - RD_ISSUE / RD_WAIT: same handshake as the write, with sccb_rw=1. Then go to COMPARE.
  - COMPARE: sample sccb_rdata in the cycle sccb_ready is seen high.
    - Equal to data: clear retry count, go to NEXT.
    - Mismatch with retry < MAX_RETRY: increment retry, go to WR_ISSUE.
    - Otherwise: go to FAIL.
  - DELAY: a millisecond tick counter counts CLK_FREQ/1000 cycles per tick; decrement the remaining count per tick. A count of 0 leaves after 1 cycle. Go to NEXT.
  - NEXT:
    - If rom_addr = 2^ROM_AW-1: go to DONE (implicit END, no wrap).
    - Else increment rom_addr, go to FETCH.
  - DONE: busy=0, done=1.
  - FAIL: busy=0, done=1, error=1, err_addr=rom_addr of the failing entry.
  - From DONE or FAIL, start restarts as from IDLE.
- start while busy=1 is ignored.
- Exactly one sccb_start pulse per transaction. sccb_start is never asserted while sccb_ready=0.
- sccb_reg_addr and sccb_wdata are held stable from the pulse until the transaction completes.
- Counter widths:
  - tick counter: $clog2(CLK_FREQ/1000);
  - delay count: 16 bits;
  - retry counter: $clog2(MAX_RETRY+1) bits.
- Latency, WRITE entry: FETCH to sccb_start is 3 cycles when sccb_ready=1.

Decomposition:
- Shared package sccb_cfg_pkg: opcode constants (OP_WRITE, OP_VERIFY, OP_DELAY, OP_END), the state enumeration, and ROM field bit positions.
- One natural sub-module: ms_delay_timer. It holds the tick prescaler plus the 16-bit down-counter, with load/busy ports.
- The FSM stays in the top module.

Test Plan:
- ROM {WRITE 12/80, WRITE 11/01, END}, SCCB model with 10-cycle transactions → exactly 2 write pulses with reg/data 12/80 then 11/01; done=1, error=0, busy=0.
- CLK_FREQ=1000 (1 cycle per ms); ROM {DELAY 5, WRITE 3A/04, END} → the sccb_start pulse for 3A/04 occurs 5 ticks (±2 cycles) after DELAY decode.
- VERIFY 40/D0; model returns D0 → one write and one read pulse, done=1, error=0.
- VERIFY 40/D0; model always returns 00, MAX_RETRY=3 → 4 writes and 4 reads; error=1, done=1, err_addr=0.
- ROM_AW=2, no END in 4 entries of WRITE → 4 writes, done=1, rom_addr stops at 3 with no wrap. Then start pulsed again → sequence reruns from address 0.
- Assert rst_n=0 during an RD_WAIT → all outputs return to reset values asynchronously. start during busy → no restart and no extra pulses.

Source files
------------

// File: rtl/sccb_config_sequencer_pkg.sv
// Shared definitions for the SCCB configuration sequencer: ROM entry layout,
// opcodes and the sequencer state encoding.
package sccb_cfg_pkg;

    // ROM entry layout: [17:16] op, [15:8] register, [7:0] data
    localparam int ROM_W  = 18;
    localparam int OP_HI  = 17;
    localparam int OP_LO  = 16;
    localparam int REG_HI = 15;
    localparam int REG_LO = 8;
    localparam int DAT_HI = 7;
    localparam int DAT_LO = 0;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_VERIFY = 2'b01;
    localparam logic [1:0] OP_DELAY  = 2'b10;
    localparam logic [1:0] OP_END    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_COMPARE,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/sccb_config_sequencer_if.sv
// Byte-level SCCB master request/response bundle. The sequencer is the
// master side (it issues transactions); the SCCB engine is the slave side.
interface sccb_config_sequencer_if;
    logic       sccb_start;
    logic       sccb_rw;
    logic [7:0] sccb_dev_addr;
    logic [7:0] sccb_reg_addr;
    logic [7:0] sccb_wdata;
    logic       sccb_ready;
    logic [7:0] sccb_rdata;

    modport master (
        output sccb_start, sccb_rw, sccb_dev_addr, sccb_reg_addr, sccb_wdata,
        input  sccb_ready, sccb_rdata
    );

    modport slave (
        input  sccb_start, sccb_rw, sccb_dev_addr, sccb_reg_addr, sccb_wdata,
        output sccb_ready, sccb_rdata
    );
endinterface

// File: rtl/sccb_config_sequencer_ms_delay_timer.sv
// Millisecond delay timer: a prescaler producing one tick per millisecond
// and a 16-bit down-counter of remaining milliseconds. busy stays high
// until the loaded count has run out; a load of 0 is never busy.
module ms_delay_timer #(
    parameter int CLK_FREQ = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] ms,
    output logic        busy
);
    // Guard against clocks under 1 kHz and a zero-width prescaler at 1 cycle/ms
    localparam int TICK_CYC = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

    logic [PW-1:0] presc;
    logic [15:0]   remain;

    // Prescaler restarts on every load so the first tick is a full millisecond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            remain <= '0;
        end else if (load) begin
            presc  <= '0;
            remain <= ms;
        end else if (remain != 16'd0) begin
            if (presc == PW'(TICK_CYC - 1)) begin
                presc  <= '0;
                remain <= remain - 16'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign busy = (remain != 16'd0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Camera configuration sequencer: walks a synchronous ROM of opcode entries
// and drives a byte-level SCCB master. Supports plain writes, writes with
// readback verify and bounded retry, millisecond delays and an END marker.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int         CLK_FREQ  = 25000000,
    parameter int         ROM_AW    = 8,
    parameter logic [7:0] DEV_ADDR  = 8'h42,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    sccb_config_sequencer_if.master sccb,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_addr
);
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t         state, state_nxt;
    logic [ROM_W-1:0] entry;
    logic [7:0]     rd_byte;
    logic [RTW-1:0] retry;
    logic           dly_busy;

    // FSM strobes into the datapath
    logic go, latch_entry, load_dly, issue, issue_rd, cap_rd;
    logic retry_inc, retry_clr, addr_inc, fail_set;

    assign sccb.sccb_dev_addr = DEV_ADDR;

    assign busy  = !(state inside {S_IDLE, S_DONE, S_FAIL});
    assign done  = (state == S_DONE) || (state == S_FAIL);
    assign error = (state == S_FAIL);

    ms_delay_timer #(.CLK_FREQ(CLK_FREQ)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_dly),
        .ms    (rom_data[REG_HI:DAT_LO]),
        .busy  (dly_busy)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath strobes. sccb_start is high only in the first
    // wait cycle, so it doubles as the "ignore stale ready" flag.
    always_comb begin
        state_nxt   = state;
        go          = 1'b0;
        latch_entry = 1'b0;
        load_dly    = 1'b0;
        issue       = 1'b0;
        issue_rd    = 1'b0;
        cap_rd      = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        addr_inc    = 1'b0;
        fail_set    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                latch_entry = 1'b1;
                case (rom_data[OP_HI:OP_LO])
                    OP_WRITE, OP_VERIFY: state_nxt = S_WR_ISSUE;
                    OP_DELAY: begin
                        load_dly  = 1'b1;
                        state_nxt = S_DELAY;
                    end
                    default: state_nxt = S_DONE;
                endcase
            end
            S_WR_ISSUE: begin
                if (sccb.sccb_ready) begin
                    issue     = 1'b1;
                    state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (!sccb.sccb_start && sccb.sccb_ready)
                    state_nxt = (entry[OP_HI:OP_LO] == OP_VERIFY) ? S_RD_ISSUE : S_NEXT;
            end
            S_RD_ISSUE: begin
                if (sccb.sccb_ready) begin
                    issue     = 1'b1;
                    issue_rd  = 1'b1;
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (!sccb.sccb_start && sccb.sccb_ready) begin
                    cap_rd    = 1'b1;
                    state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (rd_byte == entry[DAT_HI:DAT_LO]) begin
                    retry_clr = 1'b1;
                    state_nxt = S_NEXT;
                end else if (retry < RTW'(MAX_RETRY)) begin
                    retry_inc = 1'b1;
                    state_nxt = S_WR_ISSUE;
                end else begin
                    fail_set  = 1'b1;
                    state_nxt = S_FAIL;
                end
            end
            S_DELAY: begin
                if (!dly_busy) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                // Last ROM word acts as an implicit END; the address never wraps
                if (rom_addr == '1) begin
                    state_nxt = S_DONE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: ROM address, latched entry, SCCB request fields, retry, error address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr           <= '0;
            entry              <= '0;
            rd_byte            <= '0;
            retry              <= '0;
            err_addr           <= '0;
            sccb.sccb_start    <= 1'b0;
            sccb.sccb_rw       <= 1'b0;
            sccb.sccb_reg_addr <= '0;
            sccb.sccb_wdata    <= '0;
        end else begin
            sccb.sccb_start <= issue;
            if (go) begin
                rom_addr <= '0;
                retry    <= '0;
            end else if (addr_inc) begin
                rom_addr <= rom_addr + 1'b1;
            end
            if (latch_entry) entry <= rom_data;
            // Request fields change only at a new pulse, so they hold through the transaction
            if (issue) begin
                sccb.sccb_rw       <= issue_rd;
                sccb.sccb_reg_addr <= entry[REG_HI:REG_LO];
                sccb.sccb_wdata    <= entry[DAT_HI:DAT_LO];
            end
            if (cap_rd)    rd_byte  <= sccb.sccb_rdata;
            if (retry_clr) retry    <= '0;
            if (retry_inc) retry    <= retry + 1'b1;
            if (fail_set)  err_addr <= rom_addr;
        end
    end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Scoreboard bench for sccb_config_sequencer: directed ROM programs push the
// expected SCCB transactions into a queue; a monitor pops and checks them on
// every sccb_start pulse.
module tb_sccb_config_sequencer;
    import sccb_cfg_pkg::*;

    localparam int AW = 2;

    typedef struct packed {
        logic       rw;
        logic [7:0] r;
        logic [7:0] d;
    } tx_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [17:0]   rom_data = '0;
    logic          busy, done, error;
    logic [AW-1:0] err_addr;

    sccb_config_sequencer_if bus();

    sccb_config_sequencer #(
        .CLK_FREQ(1000), .ROM_AW(AW), .DEV_ADDR(8'h42), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb(bus),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pulse_cyc = 0;
    bit saw_read = 1'b0;
    tx_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous configuration ROM
    logic [17:0] rom [4];
    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // SCCB master model: 10-cycle transactions, register file readback,
    // or a stuck 00 read when bad_read is set
    logic       m_ready = 1'b1;
    logic [7:0] m_rdata = 8'h00;
    logic       m_rw = 1'b0;
    logic [7:0] m_reg = 8'h00, m_dat = 8'h00;
    logic [7:0] regs [256];
    bit         bad_read = 1'b0;
    int         m_cnt = 0;
    assign bus.sccb_ready = m_ready;
    assign bus.sccb_rdata = m_rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
        end else if (bus.sccb_start && m_ready) begin
            m_ready <= 1'b0;
            m_cnt   <= 10;
            m_rw    <= bus.sccb_rw;
            m_reg   <= bus.sccb_reg_addr;
            m_dat   <= bus.sccb_wdata;
        end else if (!m_ready) begin
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                if (m_rw) m_rdata <= bad_read ? 8'h00 : regs[m_reg];
                else      regs[m_reg] <= m_dat;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Monitor: scoreboard pop on each pulse, plus request-field stability
    always @(negedge clk) begin
        tx_t e;
        if (rst_n && bus.sccb_start) begin
            pulse_cyc = cyc;
            if (bus.sccb_rw) saw_read = 1'b1;
            chk("pulse_while_ready", bus.sccb_ready, 1'b1);
            chk("pulse_dev_addr", bus.sccb_dev_addr, 8'h42);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {bus.sccb_rw, bus.sccb_reg_addr, bus.sccb_wdata}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_rw", bus.sccb_rw, e.rw);
                chk("pulse_reg", bus.sccb_reg_addr, e.r);
                if (!e.rw) chk("pulse_wdata", bus.sccb_wdata, e.d);
            end
        end else if (rst_n && !m_ready) begin
            chk("hold_reg", bus.sccb_reg_addr, m_reg);
            chk("hold_wdata", bus.sccb_wdata, m_dat);
        end
    end

    task automatic push(input logic rw, input logic [7:0] r, input logic [7:0] d);
        tx_t t;
        t.rw = rw; t.r = r; t.d = d;
        exp_q.push_back(t);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        start_cyc = cyc;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n < 3000), 1'b1);
    endtask

    task automatic set_rom(input logic [17:0] a, b, c, d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic end_checks(input string name, input logic e_err);
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_error"}, error, e_err);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    localparam logic [17:0] END_E = {OP_END, 16'h0000};

    initial begin
        int d0, d5, n;
        set_rom(END_E, END_E, END_E, END_E);
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_start", bus.sccb_start, 0);
        chk("rst_rw", bus.sccb_rw, 0);
        chk("rst_reg", bus.sccb_reg_addr, 0);
        chk("rst_wdata", bus.sccb_wdata, 0);
        chk("rst_dev", bus.sccb_dev_addr, 8'h42);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Two plain writes; start re-pulsed while busy must be ignored
        set_rom({OP_WRITE, 16'h1280}, {OP_WRITE, 16'h1101}, END_E, END_E);
        push(0, 8'h12, 8'h80);
        push(0, 8'h11, 8'h01);
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        chk("busy_during_run", busy, 1'b1);
        wait_done("wr2");
        end_checks("wr2", 1'b0);

        // Verify that passes first time
        set_rom({OP_VERIFY, 16'h40D0}, END_E, END_E, END_E);
        push(0, 8'h40, 8'hD0);
        push(1, 8'h40, 8'h00);
        pulse_start();
        wait_done("vfy_ok");
        end_checks("vfy_ok", 1'b0);

        // Verify that never matches: 1 + MAX_RETRY write/read pairs then FAIL
        bad_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h40, 8'hD0);
            push(1, 8'h40, 8'h00);
        end
        pulse_start();
        wait_done("vfy_bad");
        end_checks("vfy_bad", 1'b1);
        chk("vfy_bad_err_addr", err_addr, 0);
        bad_read = 1'b0;

        // Full ROM without END: stops at the last address, then reruns from 0
        set_rom({OP_WRITE, 16'h0111}, {OP_WRITE, 16'h0222}, {OP_WRITE, 16'h0333}, {OP_WRITE, 16'h0444});
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i <= 4; i++) push(0, 8'(i), 8'(i * 17));
            pulse_start();
            wait_done("full");
            end_checks("full", 1'b0);
            chk("full_rom_addr", rom_addr, 2'd3);
        end

        // DELAY 5 vs DELAY 0: the write pulse moves by 5 ms ticks (1 cycle each)
        set_rom({OP_DELAY, 16'd0}, {OP_WRITE, 16'h3A04}, END_E, END_E);
        push(0, 8'h3A, 8'h04);
        pulse_start();
        wait_done("dly0");
        end_checks("dly0", 1'b0);
        d0 = pulse_cyc - start_cyc;
        rom[0] = {OP_DELAY, 16'd5};
        push(0, 8'h3A, 8'h04);
        pulse_start();
        wait_done("dly5");
        end_checks("dly5", 1'b0);
        d5 = pulse_cyc - start_cyc;
        n_chk++;
        if (d5 - d0 < 3 || d5 - d0 > 7) begin
            n_fail++;
            $display("FAIL dly5_ticks: got %0d extra cycles expected 5 (+/-2)", d5 - d0);
        end

        // Reset during the readback wait abandons everything
        set_rom({OP_VERIFY, 16'h55AA}, END_E, END_E, END_E);
        push(0, 8'h55, 8'hAA);
        push(1, 8'h55, 8'h00);
        saw_read = 1'b0;
        pulse_start();
        n = 0;
        while (!saw_read && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rdwait_reached", (n < 200), 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        chk("arst_err_addr", err_addr, 0);
        chk("arst_start", bus.sccb_start, 0);
        chk("arst_rw", bus.sccb_rw, 0);
        chk("arst_reg", bus.sccb_reg_addr, 0);
        chk("arst_wdata", bus.sccb_wdata, 0);
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
